// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 8 data + odd parity, stop, ACK.
// Optional watchdog on device clock edges is built when PS2_TX_TIMEOUT_EN is defined.
module ps2_host_tx #(
   parameter int INHIBIT_CYCLES = 5000,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2Clk,
   input  logic       ps2Data,
   output logic       ps2ClkOe,
   output logic       ps2DataOe,
   input  logic       txStart,
   input  logic [7:0] txByte,
   output logic       txBusy,
   output logic       txDone,
   output logic       txErr
);
   localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_INHIBIT,
      S_START,
      S_BITS,
      S_STOP,
      S_ACK,
      S_WAITIDLE
   } state_t;

   state_t           state_q;
   logic [1:0]       clk_sync_q;
   logic [1:0]       data_sync_q;
   logic             clk_prev_q;
   logic [INH_W-1:0] inh_cnt_q;
   logic [8:0]       shift_q;
   logic [3:0]       bit_cnt_q;
   logic             clk_s;
   logic             data_s;
   logic             fe;
   logic             to_hit;

   assign clk_s  = clk_sync_q[1];
   assign data_s = data_sync_q[1];
   assign fe     = clk_prev_q & ~clk_s;

   // Synchronizers reset to the idle (released) bus level so no false edge follows reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         clk_sync_q  <= 2'b11;
         data_sync_q <= 2'b11;
         clk_prev_q  <= 1'b1;
      end else begin
         clk_sync_q  <= {clk_sync_q[0], ps2Clk};
         data_sync_q <= {data_sync_q[0], ps2Data};
         clk_prev_q  <= clk_s;
      end
   end

`ifdef PS2_TX_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TO_W-1:0] to_cnt_q;
   logic            to_active;

   assign to_active = (state_q == S_START) || (state_q == S_BITS) || (state_q == S_STOP) ||
                      (state_q == S_ACK) || (state_q == S_WAITIDLE);
   assign to_hit    = to_active && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

   // Restarts on every device clock edge; WAITIDLE simply keeps counting from the last one.
   always_ff @(posedge clk) begin
      if (!rst || !to_active || to_hit) begin
         to_cnt_q <= '0;
      end else if (fe && state_q != S_WAITIDLE) begin
         to_cnt_q <= '0;
      end else begin
         to_cnt_q <= to_cnt_q + 1'b1;
      end
   end
`else
   assign to_hit = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         ps2ClkOe  <= 1'b0;
         ps2DataOe <= 1'b0;
         txBusy    <= 1'b0;
         txDone    <= 1'b0;
         txErr     <= 1'b0;
         inh_cnt_q <= '0;
         shift_q   <= '0;
         bit_cnt_q <= '0;
      end else begin
         txDone <= 1'b0;
         txErr  <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (txStart) begin
                  shift_q   <= {~^txByte, txByte};
                  bit_cnt_q <= '0;
                  inh_cnt_q <= '0;
                  ps2ClkOe  <= 1'b1;
                  txBusy    <= 1'b1;
                  state_q   <= S_INHIBIT;
               end
            end
            S_INHIBIT: begin
               if (inh_cnt_q == INH_W'(INHIBIT_CYCLES - 1)) begin
                  ps2ClkOe  <= 1'b0;
                  ps2DataOe <= 1'b1;
                  state_q   <= S_START;
               end else begin
                  inh_cnt_q <= inh_cnt_q + 1'b1;
               end
            end
            S_START: state_q <= S_BITS;
            S_BITS: begin
               // Data bits then parity shift out LSB first, one per device clock fall.
               if (fe) begin
                  ps2DataOe <= ~shift_q[0];
                  shift_q   <= {1'b0, shift_q[8:1]};
                  bit_cnt_q <= bit_cnt_q + 1'b1;
                  if (bit_cnt_q == 4'd8) state_q <= S_STOP;
               end
            end
            S_STOP: begin
               if (fe) begin
                  ps2DataOe <= 1'b0;
                  state_q   <= S_ACK;
               end
            end
            S_ACK: begin
               if (fe) begin
                  if (!data_s) begin
                     state_q <= S_WAITIDLE;
                  end else begin
                     txErr   <= 1'b1;
                     txBusy  <= 1'b0;
                     state_q <= S_IDLE;
                  end
               end
            end
            S_WAITIDLE: begin
               if (clk_s && data_s) begin
                  txDone  <= 1'b1;
                  txBusy  <= 1'b0;
                  state_q <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
         if (to_hit) begin
            ps2ClkOe  <= 1'b0;
            ps2DataOe <= 1'b0;
            txErr     <= 1'b1;
            txBusy    <= 1'b0;
            state_q   <= S_IDLE;
         end
      end
   end
endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter. It sends one command byte, such as 0xED (set LEDs) or 0xF4 (enable), from the FPGA to the keyboard on the same open-drain ps2Clk/ps2Data pair that the keyboard receive path listens to. It sits next to the receive logic in the PS2 block. It owns the bus only while a transfer is in progress; otherwise both lines are released.

## Interface
- `INHIBIT_CYCLES`, default 5000. Number of clk cycles that ps2Clk is held low before the start bit (100 µs at 50 MHz).
- `TIMEOUT_CYCLES`, default 1000000. Watchdog limit in clk cycles between device clock falling edges (20 ms). Used only with `PS2_TX_TIMEOUT_EN`.

Ports:
- `clk` in 1: system clock, 50 MHz.
- `rst` in 1: reset, synchronous, active-low. The block is in reset while rst=0, sampled on the rising edge of clk.
- `ps2Clk` in 1: PS/2 clock line as seen at the pad.
- `ps2Data` in 1: PS/2 data line as seen at the pad.
- `ps2ClkOe` out 1: 1 = drive the PS/2 clock pad low; 0 = release (high-Z).
- `ps2DataOe` out 1: 1 = drive the PS/2 data pad low; 0 = release.
- `txStart` in 1: one-cycle request; `txByte` is captured on the same cycle.
- `txByte` in 8: command byte to send.
- `txBusy` out 1: high from the cycle after an accepted `txStart` until the cycle `txDone` or `txErr` pulses.
- `txDone` out 1: one-cycle pulse; the device acknowledged the byte.
- `txErr` out 1: one-cycle pulse; no ACK, or a timeout.

## Operation
- `ps2Clk` and `ps2Data` each pass through a 2-FF synchronizer.
- A falling edge (`fe`) is defined as synchronized clock previous=1, current=0.
- Odd parity: `parity = ~^txByte`.
- State machine: IDLE → INHIBIT → START → BITS → STOP → ACK → WAITIDLE → IDLE.
- IDLE: `ps2ClkOe=0`, `ps2DataOe=0`. `txStart` latches `txByte`, computes parity, clears the bit counter and goes to INHIBIT.
- INHIBIT: `ps2ClkOe=1`. After `INHIBIT_CYCLES` cycles, set `ps2DataOe=1` (start bit 0) and go to START.
- START: `ps2ClkOe=0`, `ps2DataOe` stays 1. The device now generates the clock.
- BITS: on each `fe`, drive the next bit, LSB first: `ps2DataOe = ~bit`. The sequence is data[0..7] on `fe` 1–8, then parity on `fe` 9. After `fe` 9, go to STOP.
- STOP: on `fe` 10, set `ps2DataOe=0` (stop bit 1, line released) and go to ACK.
- ACK: on `fe` 11, sample the synchronized `ps2Data`.
  - 0 = ACK: go to WAITIDLE.
  - 1 = no ACK: pulse `txErr` and go to IDLE.
- WAITIDLE: wait until the synchronized `ps2Clk` and `ps2Data` are both 1, then pulse `txDone` and go to IDLE.
- `txStart` is ignored when the state is not IDLE. The latched byte is not changed.
- The block never drives a line high; the Oe signals only ever pull low.

## Timing
- Reset values: `ps2ClkOe=0`, `ps2DataOe=0`, `txBusy=0`, `txDone=0`, `txErr=0`, state IDLE, counters 0.
- `ps2ClkOe` rises on the clk edge after `txStart`.
- Synchronizer latency is 2 cycles. `ps2DataOe` updates 3 clk cycles after the pad's falling edge, well inside the ≥5 µs half-period of the PS/2 clock.
- The inhibit pulse is exactly `INHIBIT_CYCLES` cycles of `ps2ClkOe=1`.
- `ps2DataOe` rises on the same edge that `ps2ClkOe` falls.
- `txDone` and `txErr` are registered and high for exactly 1 cycle. `txBusy` falls on that same edge.
- Reset mid-frame: both Oe outputs drop to 0 on the next clk edge, with no pulse on `txDone` or `txErr`.
- A glitch on `ps2Clk` shorter than 2 clk cycles may be missed. This is accepted.

## Configuration
- `PS2_TX_TIMEOUT_EN` defined:
  - A counter runs in START, BITS, STOP and ACK. It resets on every `fe`.
  - When it reaches `TIMEOUT_CYCLES`, release both lines, pulse `txErr` and go to IDLE.
  - WAITIDLE is also bounded by the same limit, with the same error result.
- `PS2_TX_TIMEOUT_EN` undefined:
  - No counter is built.
  - The state machine waits indefinitely for device clocks. Only `rst` recovers it.

## Test plan
- Send 0xED. The device model clocks at 10 kHz and ACKs on `fe` 11. Required: data observed at device rising edges is 0,1,0,1,1,0,1,1,1, then parity 1, then stop 1. `txDone` pulses once and `txErr` stays 0.
- Send 0xF4. Required: bits 0,0,0,1,0,1,1,1,1, then parity 0. `ps2ClkOe` high for exactly 5000 cycles.
- Send 0x00 with the device holding data high on `fe` 11 (no ACK). Required: parity 1, `txErr` pulses, `txDone` stays 0, both Oe signals are 0 afterwards.
- Pulse `txStart` with 0x55 during an active 0xED frame. Required: it is ignored and the bits on the wire remain those of 0xED.
- Drive `rst`=0 after `fe` 5. Required: both Oe signals are 0 on the next cycle and `txBusy` is 0. A following 0xF4 then completes normally.
- With `PS2_TX_TIMEOUT_EN` defined and the device never clocking: `txErr` pulses `TIMEOUT_CYCLES` cycles after the inhibit period ends. Without the macro, `txBusy` stays 1 indefinitely.
